// File: rtl/ahb_arbiter.sv
// Three-master AHB arbiter: round-robin grant, beat-limited tenures, and
// address/data-phase multiplexing towards a single bridge.
module ahb_arbiter #(
  parameter int MAX_BEATS = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [2:0]  hbusreq,
  input  logic [95:0] haddr_m,
  input  logic [5:0]  htrans_m,
  input  logic [2:0]  hwrite_m,
  input  logic [95:0] hwdata_m,
  input  logic        hreadyout,
  output logic [2:0]  hgrant,
  output logic [1:0]  hmaster,
  output logic [1:0]  hmaster_d,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] hwdata
);

  typedef enum logic {PARK, OWN} state_t;

  localparam logic [7:0] max_beats8 = 8'(MAX_BEATS);

  state_t     state, state_nxt;
  logic [1:0] hmaster_nxt;
  logic [1:0] last_owner, last_owner_nxt;
  logic [7:0] beat_cnt, beat_cnt_nxt, beat_inc;
  logic [2:0] owner_oh, others;
  logic [1:0] trans_sel;

  // First requester at base+1, base+2, base+3 (mod 3); nearest distance wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(base) + k) % 3);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [31:0] sel32(input logic [95:0] bus, input logic [1:0] idx);
    case (idx)
      2'd1:    sel32 = bus[63:32];
      2'd2:    sel32 = bus[95:64];
      default: sel32 = bus[31:0];
    endcase
  endfunction

  always_comb begin
    case (hmaster)
      2'd1:    begin trans_sel = htrans_m[3:2]; hwrite = hwrite_m[1]; end
      2'd2:    begin trans_sel = htrans_m[5:4]; hwrite = hwrite_m[2]; end
      default: begin trans_sel = htrans_m[1:0]; hwrite = hwrite_m[0]; end
    endcase
  end

  assign owner_oh = 3'b001 << hmaster;
  assign hgrant   = (state == OWN) ? owner_oh : 3'b001;
  assign haddr    = sel32(haddr_m, hmaster);
  assign htrans   = (state == OWN) ? trans_sel : 2'b00;
  assign hwdata   = sel32(hwdata_m, hmaster_d);

  assign others   = hbusreq & ~owner_oh;
  assign beat_inc = beat_cnt + 8'(htrans[1]);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt      = state;
    hmaster_nxt    = hmaster;
    beat_cnt_nxt   = beat_cnt;
    last_owner_nxt = last_owner;
    if (hreadyout) begin
      case (state)
        PARK: begin
          if (|hbusreq) begin
            state_nxt    = OWN;
            hmaster_nxt  = rr_pick(hbusreq, last_owner);
            beat_cnt_nxt = 8'd0;
          end
        end
        OWN: begin
          last_owner_nxt = hmaster;
          beat_cnt_nxt   = beat_inc;
          if ((hbusreq & owner_oh) == 3'b000) begin
            beat_cnt_nxt = 8'd0;
            if (|others) begin
              hmaster_nxt = rr_pick(others, hmaster);
            end else begin
              state_nxt   = PARK;
              hmaster_nxt = 2'd0;
            end
          end else if (beat_inc == max_beats8) begin
            // Tenure limit: hand over only if someone else is waiting.
            beat_cnt_nxt = 8'd0;
            if (|others) hmaster_nxt = rr_pick(others, hmaster);
          end
        end
        default: state_nxt = PARK;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= PARK;
      hmaster    <= 2'd0;
      hmaster_d  <= 2'd0;
      beat_cnt   <= 8'd0;
      last_owner <= 2'd2;
    end else begin
      state      <= state_nxt;
      hmaster    <= hmaster_nxt;
      beat_cnt   <= beat_cnt_nxt;
      last_owner <= last_owner_nxt;
      if (hreadyout) hmaster_d <= hmaster;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (MAX_BEATS=4): grant order, phase muxing,
// tenure limit, wait-state hold and asynchronous reset.
module tb_ahb_arbiter;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  hbusreq;
  logic [95:0] haddr_m;
  logic [5:0]  htrans_m;
  logic [2:0]  hwrite_m;
  logic [95:0] hwdata_m;
  logic        hreadyout;
  logic [2:0]  hgrant;
  logic [1:0]  hmaster;
  logic [1:0]  hmaster_d;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ahb_arbiter #(.MAX_BEATS(4)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .haddr_m   (haddr_m),
    .htrans_m  (htrans_m),
    .hwrite_m  (hwrite_m),
    .hwdata_m  (hwdata_m),
    .hreadyout (hreadyout),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hwdata    (hwdata)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_cnt++;
  endtask

  // One rising edge, then back to the falling edge where outputs are sampled.
  task automatic tick();
    @(negedge hclk);
  endtask

  task automatic reset_pulse();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  initial begin
    hreset    = 1'b1;
    hbusreq   = 3'b000;
    haddr_m   = {32'h0000_2000, 32'h0000_8000, 32'h0000_1000};
    hwdata_m  = {32'h2222_2222, 32'hA5A5_A5A5, 32'h1111_1111};
    htrans_m  = 6'b10_10_10;
    hwrite_m  = 3'b010;
    hreadyout = 1'b1;

    #1;
    check("rst_hgrant",    32'(hgrant),    32'h1);
    check("rst_htrans",    32'(htrans),    32'h0);
    check("rst_hmaster",   32'(hmaster),   32'h0);
    check("rst_hmaster_d", 32'(hmaster_d), 32'h0);

    // All three request; each owner drops after one beat.
    tick();
    hreset  = 1'b0;
    hbusreq = 3'b111;
    #1;
    check("park_htrans_forced", 32'(htrans), 32'h0);
    tick();
    check("rr_grant0",  32'(hgrant), 32'h1);
    check("rr_htrans0", 32'(htrans), 32'h2);
    hbusreq = 3'b110;
    tick();
    check("rr_grant1", 32'(hgrant), 32'h2);
    hbusreq = 3'b100;
    tick();
    check("rr_grant2", 32'(hgrant), 32'h4);
    hbusreq = 3'b000;
    tick();
    check("park_hgrant",    32'(hgrant),    32'h1);
    check("park_htrans",    32'(htrans),    32'h0);
    check("park_hmaster_d", 32'(hmaster_d), 32'h2);

    // Master 1 alone: address in cycle N, write data in cycle N+1.
    hbusreq = 3'b010;
    tick();
    check("m1_hmaster", 32'(hmaster), 32'h1);
    check("m1_haddr",   haddr,        32'h0000_8000);
    check("m1_hwrite",  32'(hwrite),  32'h1);
    check("m1_hwdata_n", hwdata,      32'h1111_1111);
    tick();
    check("m1_hmaster_d", 32'(hmaster_d), 32'h1);
    check("m1_hwdata",    hwdata,         32'hA5A5_A5A5);

    // Masters 0 and 2 streaming SEQ: ownership alternates every 4 beats.
    reset_pulse();
    htrans_m = 6'b11_11_11;
    hbusreq  = 3'b101;
    tick();
    check("lim_entry", 32'(hgrant), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("lim_k%0d", k), 32'(hgrant), ((k / 4) % 2 == 0) ? 32'h1 : 32'h4);
    end

    // Lone requester hits the limit and keeps the bus.
    hbusreq = 3'b100;
    for (int k = 0; k < 6; k++) tick();
    check("retain_hgrant", 32'(hgrant), 32'h4);

    // Owner drops request during wait states; handover waits for ready.
    reset_pulse();
    htrans_m = 6'b00_00_00;
    hbusreq  = 3'b011;
    tick();
    check("wait_entry", 32'(hgrant), 32'h1);
    hreadyout = 1'b0;
    hbusreq   = 3'b010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wait_hold%0d", k), 32'(hgrant), 32'h1);
    end
    hreadyout = 1'b1;
    tick();
    check("wait_handover", 32'(hgrant), 32'h2);

    // Asynchronous reset while master 2 owns with SEQ.
    reset_pulse();
    htrans_m = 6'b11_00_00;
    hbusreq  = 3'b100;
    tick();
    tick();
    check("own2_hmaster_d", 32'(hmaster_d), 32'h2);
    check("own2_htrans",    32'(htrans),    32'h3);
    #2 hreset = 1'b1;
    #1;
    check("async_hgrant",    32'(hgrant),    32'h1);
    check("async_htrans",    32'(htrans),    32'h0);
    check("async_hmaster_d", 32'(hmaster_d), 32'h0);
    #1 hreset = 1'b0;
    tick();
    check("post_rst_grant", 32'(hgrant), 32'h4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_BEATS, default 16, meaning the maximum number of accepted beats per tenure before forced rearbitration (legal range 1..255).
REQ-002 The module SHALL have these ports, in this order:
- hclk, input, 1 bit: the single clock; all state updates on the rising edge.
- hreset, input, 1 bit: asynchronous, active-high reset.
- hbusreq, input, 3 bits: bus request, bit i from master i.
- haddr_m, input, 96 bits: master addresses; master i at [32i+31:32i].
- htrans_m, input, 6 bits: master transfer types; master i at [2i+1:2i].
- hwrite_m, input, 3 bits: master write flags.
- hwdata_m, input, 96 bits: master write data; master i at [32i+31:32i].
- hreadyout, input, 1 bit: ready from the bridge.
- hgrant, output, 3 bits: one-hot grant.
- hmaster, output, 2 bits: address-phase owner index.
- hmaster_d, output, 2 bits: data-phase owner index.
- haddr, output, 32 bits: muxed address to the bridge.
- htrans, output, 2 bits: muxed transfer type to the bridge.
- hwrite, output, 1 bit: muxed write flag to the bridge.
- hwdata, output, 32 bits: muxed write data to the bridge.

Function
REQ-003 The arbiter SHALL implement two states: PARK (no requester; master 0 parked) and OWN (hmaster holds the bus).
REQ-004 In PARK the outputs SHALL be: hgrant=3'b001, hmaster=0, and htrans forced to 2'b00 (IDLE) regardless of htrans_m.
REQ-005 In OWN the outputs SHALL be: hgrant=one-hot(hmaster); haddr, htrans and hwrite combinationally selected from master hmaster.
REQ-006 hwdata SHALL always be combinationally selected from master hmaster_d.
REQ-007 Arbitration decisions (state, hmaster, hgrant) SHALL update only on rising edges where hreadyout=1; while hreadyout=0, all arbitration state SHALL hold.
REQ-008 On every edge with hreadyout=1, hmaster_d SHALL load hmaster, giving a one-beat data-phase lag.
REQ-009 The beat counter (8 bits) SHALL increment on each edge in OWN with hreadyout=1 and htrans[1]=1 (NONSEQ/SEQ accepted).
REQ-010 The beat counter SHALL clear to 0 on every change of owner and on entry to OWN.
REQ-011 Rearbitration SHALL occur on an hreadyout=1 edge in OWN when either:
- hbusreq[hmaster]=0, or
- the post-increment count equals MAX_BEATS and another master requests.
REQ-012 The new owner SHALL be the first requesting master searched round-robin from hmaster+1 (mod 3), skipping the current owner unless it is the only requester.
REQ-013 In PARK, with any hbusreq bit set on an hreadyout=1 edge, the next state SHALL be OWN with owner chosen round-robin from last_owner+1.
REQ-014 After reset, last_owner SHALL be 2, so a simultaneous request from all masters grants master 0 first.
REQ-015 When the owner releases and no other master requests, the next state SHALL be PARK and last_owner SHALL keep the releasing index.
REQ-016 When MAX_BEATS is reached and no other master requests, the owner SHALL retain the bus and the counter SHALL clear to 0.
REQ-017 A request deasserted while hreadyout=0 SHALL be acted on only at the next hreadyout=1 edge.
REQ-018 hgrant SHALL never have more than one bit set.
REQ-019 Grant latency from request (in PARK, hreadyout=1) SHALL be exactly one clock.

Reset
REQ-020 Assertion of hreset SHALL immediately set:
- state to PARK
- hgrant to 3'b001
- hmaster and hmaster_d to 0
- the beat counter to 0
- last_owner to 2
REQ-021 While hreset=1, htrans SHALL output 2'b00.
REQ-022 Reset asserted mid-transfer SHALL abort the tenure with no completion beat; the first arbitration SHALL occur on the first rising edge after deassertion.

Verification
REQ-023 Reset, then hbusreq=3'b111 with hreadyout=1: hgrant SHALL be 001, then 010, then 100, as each owner drops its request after one beat.
REQ-024 Master 1 requests alone, issues NONSEQ 0x0000_8000 write with data 0xA5A5_A5A5: haddr SHALL be 0x8000 in cycle N and hwdata SHALL be 0xA5A5_A5A5 in cycle N+1, with hmaster_d=1.
REQ-025 Masters 0 and 2 both request continuously, MAX_BEATS=4, all beats SEQ and ready: ownership SHALL alternate every 4 accepted beats (0,2,0,...).
REQ-026 Owner 0 drops hbusreq while hreadyout=0 for 3 cycles, master 1 requesting: hgrant SHALL stay 001 until the first hreadyout=1 edge, then become 010.
REQ-027 hreset pulsed while master 2 owns with htrans=SEQ: hgrant SHALL be 001 and htrans 00 asynchronously, and hmaster_d SHALL be 0.
REQ-028 All requests drop: the state SHALL be PARK, htrans SHALL be 00 even if htrans_m[1:0]=2'b10, and hgrant SHALL be 001.
